// File: rtl/ts_input_arbiter.sv
// Two-source TS packet arbiter: round-robin grant per whole packet, sync-byte and
// stall checking, one-cycle registered output. Define TS_ARB_NULL_FILL_EN for null-packet fill.
module ts_input_arbiter #(
  parameter int PKT_LEN = 188,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic       dvalid_a,
  input  logic       dvalid_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [7:0] data_out,
  output logic       dvalid_out,
  output logic       psync_out,
  output logic [1:0] src_id,
  output logic       err_sync,
  output logic       err_timeout,
  output logic [1:0] fsm_state
);

  localparam int CW = $clog2(PKT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(PKT_LEN - 1);
  localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_A  = 2'd1,
    GRANT_B  = 2'd2,
    NULL_PKT = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic          last_b;
  logic          armed;
  logic          bad_sync;

  logic          sel_b;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          pick_a;

`ifdef TS_ARB_NULL_FILL_EN
  // Null packet: PID 0x1FFF, payload-only adaptation field control, stuffing payload.
  function automatic logic [7:0] null_byte(input logic [CW-1:0] idx);
    case (idx)
      CW'(0):  null_byte = 8'h47;
      CW'(1):  null_byte = 8'h1F;
      CW'(2):  null_byte = 8'hFF;
      CW'(3):  null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  endfunction
`endif

  always_comb begin
    sel_b     = (state == GRANT_B);
    sel_data  = sel_b ? data_b : data_a;
    sel_valid = ((state == GRANT_A) && dvalid_a) || ((state == GRANT_B) && dvalid_b);
    // A wins a tie only when B was served last.
    pick_a    = req_a && (!req_b || last_b);
  end

  assign fsm_state = state;

  // Handshake: a source byte is taken on every rising edge where the source is
  // granted and its dvalid is high; there is no backpressure toward the source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      data_out    <= 8'h00;
      dvalid_out  <= 1'b0;
      psync_out   <= 1'b0;
      src_id      <= 2'd0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      last_b      <= 1'b1;
      armed       <= 1'b0;
      bad_sync    <= 1'b0;
    end else begin
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      // The first edge after release only arms arbitration.
      armed       <= 1'b1;
      case (state)
        IDLE: begin
          dvalid_out <= 1'b0;
          psync_out  <= 1'b0;
          byte_cnt   <= '0;
          idle_cnt   <= '0;
          bad_sync   <= 1'b0;
          if (armed) begin
            if (pick_a) begin
              state <= GRANT_A;
              gnt_a <= 1'b1;
            end else if (req_b) begin
              state <= GRANT_B;
              gnt_b <= 1'b1;
            end
`ifdef TS_ARB_NULL_FILL_EN
            else begin
              state <= NULL_PKT;
            end
`endif
          end
        end

        GRANT_A, GRANT_B: begin
          if (sel_valid) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + CW'(1);
            data_out <= sel_data;
            src_id   <= sel_b ? 2'd1 : 2'd0;
            if (byte_cnt == '0) begin
              bad_sync   <= (sel_data != SYNC_BYTE);
              err_sync   <= (sel_data != SYNC_BYTE);
              dvalid_out <= (sel_data == SYNC_BYTE);
              psync_out  <= (sel_data == SYNC_BYTE);
            end else begin
              dvalid_out <= !bad_sync;
              psync_out  <= 1'b0;
            end
            if (byte_cnt == LAST_BYTE) begin
              state  <= IDLE;
              gnt_a  <= 1'b0;
              gnt_b  <= 1'b0;
              last_b <= sel_b;
            end
          end else begin
            dvalid_out <= 1'b0;
            psync_out  <= 1'b0;
            idle_cnt   <= idle_cnt + TW'(1);
            // Stalled source: drop the rest of its packet and hand over the turn.
            if (idle_cnt == LAST_IDLE) begin
              state       <= IDLE;
              gnt_a       <= 1'b0;
              gnt_b       <= 1'b0;
              err_timeout <= 1'b1;
              last_b      <= sel_b;
            end
          end
        end

        NULL_PKT: begin
`ifdef TS_ARB_NULL_FILL_EN
          dvalid_out <= 1'b1;
          psync_out  <= (byte_cnt == '0);
          data_out   <= null_byte(byte_cnt);
          src_id     <= 2'd3;
          byte_cnt   <= byte_cnt + CW'(1);
          if (byte_cnt == LAST_BYTE) begin
            state <= IDLE;
          end
`else
          dvalid_out <= 1'b0;
          psync_out  <= 1'b0;
          state      <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
